// File: rtl/mm_arbiter_if.sv
// Bundle of requester handshakes, shared result bus and multiplier-side
// signals for the mm_arbiter. The "slave" modport is the arbiter's view;
// the "master" modport is the environment's view: requesters and multiplier.
interface mm_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 4,
    parameter int COLS_A     = 4,
    parameter int COLS_B     = 4
);
    localparam int A_W   = ROWS_A * COLS_A * DATA_WIDTH;
    localparam int B_W   = COLS_A * COLS_B * DATA_WIDTH;
    localparam int C_W   = ROWS_A * COLS_B * DATA_WIDTH;
    localparam int OWN_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [C_W-1:0]         rsp_c;
    logic                   rsp_err;

    // multiplier side
    logic                   mm_in_valid;
    logic [A_W-1:0]         mm_a;
    logic [B_W-1:0]         mm_b;
    logic [C_W-1:0]         mm_c;
    logic                   mm_out_valid;
    logic                   mm_out_ready;

    // status
    logic                   busy;
    logic [OWN_W-1:0]       owner;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mm_c, mm_out_valid,
        output req_ready, rsp_valid, rsp_c, rsp_err,
               mm_in_valid, mm_a, mm_b, mm_out_ready, busy, owner
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mm_c, mm_out_valid,
        input  req_ready, rsp_valid, rsp_c, rsp_err,
               mm_in_valid, mm_a, mm_b, mm_out_ready, busy, owner
    );
endinterface

// File: rtl/mm_arbiter.sv
// mm_arbiter: round-robin scheduler sharing one mat_mul instance between
// NUM_REQ requesters. One job in flight at a time:
//   IDLE  -> pick a winner, latch its operands
//   ISSUE -> single-cycle mm_in_valid pulse
//   WAIT  -> mm_out_ready high until the product arrives
//   RESP  -> present the product to the owning requester
// Optional watchdog: define MM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles; the job then completes with rsp_c=0 and rsp_err=1.
// Without the macro there is no counter and rsp_err is constant 0.
module mm_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 4,
    parameter int COLS_A     = 4,
    parameter int COLS_B     = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          rstn,
    mm_arbiter_if.slave   bus
);
    localparam int A_W   = ROWS_A * COLS_A * DATA_WIDTH;
    localparam int B_W   = COLS_A * COLS_B * DATA_WIDTH;
    localparam int C_W   = ROWS_A * COLS_B * DATA_WIDTH;
    localparam int OWN_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    genvar gi;

    // Reject configurations the round-robin pointer and watchdog cannot handle.
    if (NUM_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mm_arbiter: NUM_REQ must be >= 2 and TIMEOUT >= 1");
    end

    state_t           state_reg, state_next;
    logic [OWN_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [OWN_W-1:0] owner_reg, owner_next;
    logic [A_W-1:0]   a_reg, a_next;
    logic [B_W-1:0]   b_reg, b_next;
    logic [C_W-1:0]   c_reg, c_next;

    logic [OWN_W-1:0] winner;
    logic             found;
    logic [OWN_W:0]   cand;
    logic [A_W-1:0]   a_sel;
    logic [B_W-1:0]   b_sel;
    logic             timeout_hit;

    // Winner search: first valid requester at or above rr_ptr, wrapping.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_reg} + (OWN_W + 1)'(i);
            if (cand >= (OWN_W + 1)'(NUM_REQ)) begin
                cand = cand - (OWN_W + 1)'(NUM_REQ);
            end
            if (bus.req_valid[cand[OWN_W-1:0]]) begin
                winner = cand[OWN_W-1:0];
                found  = 1'b1;
            end
        end
    end

    // Operand mux for the current winner's slice of the request buses.
    always_comb begin
        a_sel = bus.req_a[int'(winner) * A_W +: A_W];
        b_sel = bus.req_b[int'(winner) * B_W +: B_W];
    end

`ifdef MM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;

    // Watchdog count: zero on the way into WAIT, one step per WAIT cycle.
    always_comb begin
        cnt_next = '0;
        if (state_reg == WAIT) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // The TIMEOUT-th WAIT cycle without a product is the abort point.
    always_comb begin
        timeout_hit = (state_reg == WAIT) && (cnt_reg == CNT_W'(TIMEOUT - 1));
    end

    // Error flag follows how the WAIT state was left; held through RESP.
    always_comb begin
        err_next = err_reg;
        if (state_reg == WAIT) begin
            if (bus.mm_out_valid) begin
                err_next = 1'b0;
            end else if (timeout_hit) begin
                err_next = 1'b1;
            end
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            err_reg <= err_next;
        end
    end

    assign bus.rsp_err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Next-state and datapath-register update for the job sequencer.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        c_next      = c_reg;
        case (state_reg)
            IDLE: begin
                // req_ready[winner] is high whenever found, so this is the handshake.
                if (found) begin
                    owner_next = winner;
                    a_next     = a_sel;
                    b_next     = b_sel;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The multiplier has no input ready; the previous result was
                // drained before IDLE, so a single pulse is always accepted.
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.mm_out_valid) begin
                    c_next     = bus.mm_c;
                    state_next = RESP;
                end else if (timeout_hit) begin
                    c_next     = '0;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Only the owner's rsp_ready matters; others are ignored.
                if (bus.rsp_ready[owner_reg]) begin
                    if (owner_reg == OWN_W'(NUM_REQ - 1)) begin
                        rr_ptr_next = '0;
                    end else begin
                        rr_ptr_next = owner_reg + 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            owner_reg  <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
        end
    end

    // Per-requester grant and response strobes, both one-hot or zero.
    // Grants are suppressed while rstn is low so nothing is accepted in reset.
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
        assign bus.req_ready[gi] = rstn && (state_reg == IDLE) && found &&
                                   (winner == OWN_W'(gi));
        assign bus.rsp_valid[gi] = (state_reg == RESP) && (owner_reg == OWN_W'(gi));
    end

    assign bus.rsp_c        = c_reg;
    assign bus.mm_in_valid  = (state_reg == ISSUE);
    assign bus.mm_out_ready = (state_reg == WAIT);
    assign bus.mm_a         = a_reg;
    assign bus.mm_b         = b_reg;
    assign bus.busy         = (state_reg != IDLE);
    assign bus.owner        = owner_reg;

endmodule

// File: tb/tb_mm_arbiter.sv
// Self-checking bench for mm_arbiter: randomized requesters, a behavioural
// mat_mul stand-in with random latency, and a transaction-level model of the
// round-robin/one-job-in-flight rules that predicts every grant and result.
module tb_mm_arbiter;
    localparam int NR = 2;
    localparam int DW = 32;
    localparam int RA = 4;
    localparam int CA = 4;
    localparam int CB = 4;
    localparam int TO = 16;
    localparam int AW = RA * CA * DW;
    localparam int BW = CA * CB * DW;
    localparam int CW = RA * CB * DW;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mm_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ROWS_A(RA), .COLS_A(CA), .COLS_B(CB)) bus ();

    mm_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ROWS_A(RA), .COLS_A(CA), .COLS_B(CB), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // requester stimulus
    logic [AW-1:0] a_op [NR];
    logic [BW-1:0] b_op [NR];
    logic [NR-1:0] v  = '0;
    logic [NR-1:0] rr = '0;
    assign bus.req_valid = v;
    assign bus.rsp_ready = rr;
    assign bus.req_a     = {a_op[1], a_op[0]};
    assign bus.req_b     = {b_op[1], b_op[0]};

    // bookkeeping
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // transaction-level model
    int            m_ptr = 0;
    int            m_owner = 0;
    bit            m_busy = 1'b0;
    logic [CW-1:0] exp_c = '0;
    bit            exp_err = 1'b0;
    int            grant_cyc = -10;
    int            rsp_due = -1;
    bit            rsp_seen = 1'b0;
    bit            to_mode = 1'b0;
    int            hold = 0;
    int            hcnt = 0;
    int            g_idx = -1;
    int            d_idx = -1;
    int            grant_log[$];

    // multiplier stand-in
    logic mul_busy;
    logic mul_stall = 1'b0;
    int   mul_wait;

    function automatic logic [CW-1:0] matmul(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [CW-1:0] res;
        logic [DW-1:0] acc;
        res = '0;
        for (int r = 0; r < RA; r++) begin
            for (int c = 0; c < CB; c++) begin
                acc = '0;
                for (int k = 0; k < CA; k++) begin
                    acc = acc + a[(r*CA+k)*DW +: DW] * b[(k*CB+c)*DW +: DW];
                end
                res[(r*CB+c)*DW +: DW] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] o;
        o = '0;
        o[i] = 1'b1;
        return o;
    endfunction

    // Multiplier: accepts on in_valid, answers after 0..3 extra cycles, holds
    // out_valid until out_ready; mul_stall withholds the answer entirely.
    always @(posedge clk) begin
        if (!rstn) begin
            mul_busy         <= 1'b0;
            bus.mm_out_valid <= 1'b0;
            bus.mm_c         <= '0;
            mul_wait         <= 0;
        end else if (bus.mm_in_valid) begin
            mul_busy <= 1'b1;
            bus.mm_c <= matmul(bus.mm_a, bus.mm_b);
            mul_wait <= int'($urandom_range(0, 3));
        end else if (bus.mm_out_valid) begin
            if (bus.mm_out_ready) begin
                bus.mm_out_valid <= 1'b0;
                mul_busy         <= 1'b0;
            end
        end else if (mul_busy && !mul_stall) begin
            if (mul_wait == 0) bus.mm_out_valid <= 1'b1;
            else               mul_wait <= mul_wait - 1;
        end
    end

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_ops(input int k, input int mode);
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        for (int r = 0; r < RA; r++)
            for (int c = 0; c < CA; c++)
                a[(r*CA+c)*DW +: DW] = (mode == 2) ? DW'($urandom) :
                                       (r == c) ? DW'((mode == 1) ? 2 : 1) : '0;
        for (int r = 0; r < CA; r++)
            for (int c = 0; c < CB; c++)
                b[(r*CB+c)*DW +: DW] = (mode == 0) ? DW'(4*r + c) : DW'($urandom);
        a_op[k] = a;
        b_op[k] = b;
    endtask

    // One clock cycle: entered just after a negedge with inputs applied.
    // Compares outputs with the model, then advances the model past the edge.
    task automatic cycle();
        logic [NR-1:0] exp_ready;
        logic [NR-1:0] exp_rv;
        int w;
        #1;
        exp_ready = '0;
        g_idx = -1;
        d_idx = -1;
        w = -1;
        if (rstn && !m_busy)
            for (int i = NR - 1; i >= 0; i--)
                if (v[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
        if (w >= 0) exp_ready[w] = 1'b1;
        check("req_ready", CW'(bus.req_ready), CW'(exp_ready));
        check("busy", CW'(bus.busy), CW'(m_busy));
        if (bus.mm_in_valid) check("issue_cycle", CW'(cyc), CW'(grant_cyc + 1));
        if (m_busy && bus.mm_out_valid && bus.mm_out_ready) rsp_due = cyc + 1;
        exp_rv = (m_busy && (rsp_seen || cyc == rsp_due)) ? onehot(m_owner) : '0;
        check("rsp_valid", CW'(bus.rsp_valid), CW'(exp_rv));
        if (exp_rv != '0) begin
            check("rsp_c", bus.rsp_c, exp_c);
            check("rsp_err", CW'(bus.rsp_err), CW'(exp_err));
            check("owner", CW'(bus.owner), CW'(m_owner));
            rsp_seen = 1'b1;
            hcnt++;
            if (rr[m_owner]) d_idx = m_owner;
        end
        if (rstn && d_idx >= 0) begin
            $display("cycle %0d: job done requester=%0d err=%0b c[0]=%0h", cyc, m_owner, bus.rsp_err, bus.rsp_c[DW-1:0]);
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % NR;
        end
        if (w >= 0) begin
            m_busy    = 1'b1;
            m_owner   = w;
            exp_c     = to_mode ? '0 : matmul(a_op[w], b_op[w]);
            exp_err   = to_mode;
            grant_cyc = cyc;
            rsp_due   = to_mode ? cyc + 2 + TO : -1;
            rsp_seen  = 1'b0;
            hcnt      = 0;
            grant_log.push_back(w);
            g_idx = w;
        end
        @(negedge clk);
        cyc++;
        if (!rstn) begin
            m_busy = 1'b0; m_ptr = 0; m_owner = 0; rsp_seen = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, CW'(bus.req_ready), '0);
        check({tag, "_rsp_valid"}, CW'(bus.rsp_valid), '0);
        check({tag, "_rsp_err"}, CW'(bus.rsp_err), '0);
        check({tag, "_in_valid"}, CW'(bus.mm_in_valid), '0);
        check({tag, "_out_ready"}, CW'(bus.mm_out_ready), '0);
        check({tag, "_busy"}, CW'(bus.busy), '0);
        check({tag, "_owner"}, CW'(bus.owner), '0);
        check({tag, "_rsp_c"}, bus.rsp_c, '0);
        check({tag, "_mm_a"}, CW'(bus.mm_a), '0);
        check({tag, "_mm_b"}, CW'(bus.mm_b), '0);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        repeat (2) cycle();
        check_reset_outputs(tag);
        rstn = 1'b1;
    endtask

    // Serve n0/n1 jobs from requesters 0/1; hold<0 gives random rsp_ready.
    task automatic run_jobs(input int n0, input int n1, input int mode, input int budget);
        int left[NR];
        int done;
        int start;
        left[0] = n0;
        left[1] = n1;
        done = 0;
        start = cyc;
        for (int k = 0; k < NR; k++) new_ops(k, mode);
        while (done < n0 + n1 && cyc - start < budget) begin
            for (int k = 0; k < NR; k++) v[k] = (left[k] > 0);
            if (hold < 0) rr = NR'($urandom);
            else          rr = (hcnt >= hold) ? '1 : '0;
            cycle();
            if (g_idx >= 0) begin
                left[g_idx]--;
                new_ops(g_idx, mode);
            end
            if (d_idx >= 0) done++;
        end
        v = '0;
        check("jobs_done", CW'(done), CW'(n0 + n1));
    endtask

    task automatic start_one(input int k, input int budget);
        int n;
        n = 0;
        new_ops(k, 2);
        v = onehot(k);
        while (g_idx < 0 && n < budget) begin
            cycle();
            n++;
        end
        v = '0;
        check("start_grant", CW'(g_idx), CW'(k));
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        v = '0;
        rr = '1;
        while (m_busy && n < budget) begin
            cycle();
            n++;
        end
        check("drain", CW'(m_busy), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        new_ops(0, 0);
        new_ops(1, 0);
        v = 2'b11;
        @(negedge clk);
        do_reset("reset");

        // single job, identity A
        hold = 0;
        v = '0;
        cycle();
        run_jobs(1, 0, 0, 40);

        // both continuously valid from reset, A = 2I, alternating grants
        v = 2'b11;
        do_reset("reset2");
        grant_log.delete();
        run_jobs(4, 4, 1, 200);
        check("grant_count", CW'(grant_log.size()), CW'(8));
        for (int i = 0; i < grant_log.size(); i++) check("grant_order", CW'(grant_log[i]), CW'(i % 2));

        // result held unaccepted for 10 cycles, other requester waiting
        hold = 10;
        run_jobs(1, 1, 2, 100);
        hold = 0;

        // reset during WAIT, then a fresh job
        mul_stall = 1'b1;
        start_one(1, 20);
        repeat (4) cycle();
        check("wait_out_ready", CW'(bus.mm_out_ready), CW'(1));
        rstn = 1'b0;
        cycle();
        check_reset_outputs("midjob");
        rstn = 1'b1;
        mul_stall = 1'b0;
        run_jobs(1, 1, 2, 100);

        // multiplier never answers
        mul_stall = 1'b1;
`ifdef MM_ARB_TIMEOUT_EN
        to_mode = 1'b1;
        run_jobs(1, 0, 2, 60);
        to_mode = 1'b0;
`else
        start_one(0, 20);
        repeat (40) cycle();
        check("stall_busy", CW'(bus.busy), CW'(1));
`endif
        do_reset("reset3");
        mul_stall = 1'b0;

        // requester 1 drops its request while requester 0 is served
        grant_log.delete();
        new_ops(0, 2);
        new_ops(1, 2);
        v = 2'b11;
        rr = '1;
        n = 0;
        while (grant_log.size() < 1 && n < 20) begin cycle(); n++; end
        new_ops(0, 2);
        v = 2'b01;
        while (grant_log.size() < 2 && n < 60) begin cycle(); n++; end
        check("drop_grants", CW'(grant_log.size()), CW'(2));
        if (grant_log.size() >= 2) begin
            check("drop_first", CW'(grant_log[0]), CW'(0));
            check("drop_second", CW'(grant_log[1]), CW'(0));
        end
        drain(40);

        // random traffic: toggling valids, drops, random rsp_ready and latency
        repeat (400) begin
            v  = NR'($urandom);
            rr = NR'($urandom);
            for (int k = 0; k < NR; k++) if ($urandom_range(0, 1) == 1) new_ops(k, 2);
            cycle();
        end
        drain(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Round-robin scheduler that shares a single `mat_mul` matrix-multiplier instance between `NUM_REQ` independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and registers the winning operands. It then sequences the multiplier's `in_valid`/`out_valid`/`out_ready` protocol and returns the product to the owning requester. It sits between the AXI4-Lite register front-ends (or DMA engines) and the multiplier datapath.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, ≥2.
- `DATA_WIDTH`, 32: element width.
- `ROWS_A`, 4: rows of A and C.
- `COLS_A`, 4: columns of A, rows of B.
- `COLS_B`, 4: columns of B and C.
- `TIMEOUT`, 64: watchdog limit in WAIT cycles; used only with `MM_ARB_TIMEOUT_EN`.

Ports (matrices flattened row-major, element [r][c] at bit offset (r*COLS+c)*DATA_WIDTH, requester k occupying slice k):
- `clk`  in  1  clock, rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester job valid.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `req_a`  in  NUM_REQ*ROWS_A*COLS_A*DATA_WIDTH  A operands.
- `req_b`  in  NUM_REQ*COLS_A*COLS_B*DATA_WIDTH  B operands.
- `rsp_valid`  out  NUM_REQ  result valid, one-hot or zero.
- `rsp_ready`  in  NUM_REQ  result accept.
- `rsp_c`  out  ROWS_A*COLS_B*DATA_WIDTH  shared result bus.
- `rsp_err`  out  1  result is a watchdog abort, qualified by `rsp_valid`.
- `mm_in_valid`  out  1  to multiplier `in_valid`.
- `mm_a`  out  ROWS_A*COLS_A*DATA_WIDTH  to multiplier `a`, registered.
- `mm_b`  out  COLS_A*COLS_B*DATA_WIDTH  to multiplier `b`, registered.
- `mm_c`  in  ROWS_A*COLS_B*DATA_WIDTH  from multiplier `c`.
- `mm_out_valid`  in  1  from multiplier `out_valid`.
- `mm_out_ready`  out  1  to multiplier `out_ready`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `owner`  out  $clog2(NUM_REQ)  index of the current job's requester.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Winner = first `req_valid` bit searching upward from `rr_ptr`, wrapping at `NUM_REQ`.
  - `req_ready[winner]` is asserted combinationally in IDLE only.
  - On handshake: latch the winner's A/B into `mm_a`/`mm_b`, set `owner` to the winner, go to ISSUE.
- **ISSUE:** `mm_in_valid`=1 for exactly one cycle, then go to WAIT. The multiplier has no input-ready output. Issue is safe only because the previous result was drained before returning to IDLE. `mm_in_valid` must never be held for 2 cycles.
- **WAIT:**
  - `mm_out_ready`=1 for the whole state.
  - On `mm_out_valid`: capture `mm_c` into the result register, clear `rsp_err`, go to RESP.
- **RESP:**
  - `rsp_valid[owner]`=1; `rsp_c` and `rsp_err` are held stable.
  - On `rsp_ready[owner]`: set `rr_ptr` = (owner+1) mod `NUM_REQ`, go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- A new request is never accepted while a job is in flight. There is exactly one outstanding job.
- A requester may drop `req_valid` before it is granted. No state is kept for a dropped request.

## Timing
- Reset values: state=IDLE, `rr_ptr`=0, `owner`=0, `req_ready`=0 (while `rstn`=0), `rsp_valid`=0, `rsp_err`=0, `mm_in_valid`=0, `mm_out_ready`=0, `busy`=0, result register=0, `mm_a`/`mm_b`=0.
- Reset mid-job: the arbiter returns to IDLE. The multiplier shares `rstn` and is reset in the same cycle, so no result is delivered.
- Arbiter overhead per job:
  - 1 cycle from request handshake to `mm_in_valid`.
  - 1 cycle from the `mm_out_valid`·`mm_out_ready` edge to `rsp_valid`.
  - At least 1 cycle in RESP.
- Back-to-back:
  - The earliest next `req_ready` is the cycle after the RESP handshake.
  - With both requesters continuously valid, grants alternate 0,1,0,1.
- Simultaneous requests at reset: requester 0 wins first.

## Configuration
- `MM_ARB_TIMEOUT_EN` defined:
  - A counter runs in WAIT, cleared on entering WAIT.
  - When the counter reaches `TIMEOUT` without `mm_out_valid`, go to RESP with `rsp_c`=0 and `rsp_err`=1.
  - The multiplier's own state is not recovered; software must pulse `rstn`.
- `MM_ARB_TIMEOUT_EN` undefined:
  - No counter exists and `rsp_err` is tied to 0.
  - WAIT persists until `mm_out_valid`.

## Test plan
- Single job from requester 0: A=identity, B[r][c]=4r+c -> `mm_in_valid` pulses once, 1 cycle after the request handshake; `rsp_valid`=2'b01 with `rsp_c`=B; `rsp_err`=0.
- Both requesters valid from reset, 4 jobs each, A=2·I -> grant order 0,1,0,1,...; each `rsp_c` equals 2·B of its own requester; `req_ready` is never asserted while `busy`=1.
- Requester holds `rsp_ready`=0 for 10 cycles -> `rsp_valid`/`rsp_c` stable; no new `req_ready`; `mm_in_valid` stays 0.
- `rstn` pulsed low during WAIT -> next cycle all outputs are at reset values; a fresh job afterwards completes correctly.
- `MM_ARB_TIMEOUT_EN`, TIMEOUT=16, `mm_out_valid` forced 0 -> `rsp_valid` asserted 16 cycles after entering WAIT, with `rsp_err`=1 and `rsp_c`=0. Without the macro, same stimulus -> `busy` stays 1 indefinitely.
- Requester 1 drops `req_valid` while requester 0 is served -> the next grant goes to requester 0; no spurious `rsp_valid[1]`.
